// File: rtl/i2c_multi_agent_bus_monitor.sv
// i2c_multi_agent_bus_monitor
// Resolves an open-drain I2C bus shared by NUM_AGENTS agents and watches the
// synchronised lines. It reports START/STOP, completed bytes with their ACK
// bit, per-agent arbitration loss and START/STOP arriving inside a byte.
module i2c_multi_agent_bus_monitor #(
    parameter int NUM_AGENTS  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic [NUM_AGENTS-1:0] scl_o,
    input  logic [NUM_AGENTS-1:0] scl_oe,
    input  logic [NUM_AGENTS-1:0] sda_o,
    input  logic [NUM_AGENTS-1:0] sda_oe,
    input  logic [NUM_AGENTS-1:0] arb_clr,
    output logic                  SCL,
    output logic                  SDA,
    output logic                  bus_busy,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  byte_valid,
    output logic [7:0]            byte_data,
    output logic                  byte_ack,
    output logic [NUM_AGENTS-1:0] arb_lost,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BITS = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Wired-AND resolution. Only an enable that is definitely 1 drives the
    // line; an X/Z enable is treated as a released (pulled-up) agent.
    // ------------------------------------------------------------------
    logic [NUM_AGENTS-1:0] scl_contrib;
    logic [NUM_AGENTS-1:0] sda_contrib;
    logic [NUM_AGENTS-1:0] drive_high;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AGENTS; gi++) begin : g_agent
            assign scl_contrib[gi] = (scl_oe[gi] === 1'b1) ? scl_o[gi] : 1'b1;
            assign sda_contrib[gi] = (sda_oe[gi] === 1'b1) ? sda_o[gi] : 1'b1;
            assign drive_high[gi]  = (sda_oe[gi] === 1'b1) && (sda_o[gi] === 1'b1);
        end
    endgenerate

    assign SCL = &scl_contrib;
    assign SDA = &sda_contrib;

    // ------------------------------------------------------------------
    // Synchronisers. Intent travels through the same depth as SDA so that
    // the arbitration compare sees both from the same bus instant.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic [NUM_AGENTS-1:0]  intent_sync_reg [SYNC_STAGES];
    logic                   p_scl_reg;
    logic                   p_sda_reg;

    logic                   s_scl;
    logic                   s_sda;
    logic [NUM_AGENTS-1:0]  s_intent;

    assign s_scl    = scl_sync_reg[SYNC_STAGES-1];
    assign s_sda    = sda_sync_reg[SYNC_STAGES-1];
    assign s_intent = intent_sync_reg[SYNC_STAGES-1];

    // Shift the resolved lines and drive-high intent through the sync chain
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                intent_sync_reg[k] <= '0;
            end
            p_scl_reg <= 1'b1;
            p_sda_reg <= 1'b1;
        end else begin
            scl_sync_reg       <= {scl_sync_reg[SYNC_STAGES-2:0], SCL};
            sda_sync_reg       <= {sda_sync_reg[SYNC_STAGES-2:0], SDA};
            intent_sync_reg[0] <= drive_high;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                intent_sync_reg[k] <= intent_sync_reg[k-1];
            end
            p_scl_reg <= s_scl;
            p_sda_reg <= s_sda;
        end
    end

    // Bus conditions; START and STOP are mutually exclusive by construction
    logic scl_rise;
    logic start_cond;
    logic stop_cond;

    assign scl_rise   = !p_scl_reg && s_scl;
    assign start_cond = p_scl_reg && s_scl && p_sda_reg && !s_sda;
    assign stop_cond  = p_scl_reg && s_scl && !p_sda_reg && s_sda;

    // ------------------------------------------------------------------
    // Frame tracker state and registered outputs
    // ------------------------------------------------------------------
    state_t                state_reg,    state_next;
    logic [3:0]            bit_cnt_reg,  bit_cnt_next;
    logic [7:0]            shift_reg,    shift_next;
    logic                  busy_reg,     busy_next;
    logic                  start_reg,    start_next;
    logic                  stop_reg,     stop_next;
    logic                  bv_reg,       bv_next;
    logic [7:0]            data_reg,     data_next;
    logic                  ack_reg,      ack_next;
    logic [NUM_AGENTS-1:0] arb_reg,      arb_next;
    logic                  perr_reg,     perr_next;

    logic [3:0]            bit_cnt_inc;
    logic [NUM_AGENTS-1:0] arb_set;
    logic                  in_partial;

    // Saturating bit counter increment; the count stops at 8
    assign bit_cnt_inc = (bit_cnt_reg == 4'd8) ? 4'd8 : bit_cnt_reg + 4'd1;

    // A START/STOP here would cut a byte short (mid data bits or at ACK)
    assign in_partial = ((state_reg == ST_BITS) && (bit_cnt_reg >= 4'd1) && (bit_cnt_reg <= 4'd7))
                        || (state_reg == ST_ACK);

    // Next-state and next-output logic for the frame tracker
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        busy_next    = busy_reg;
        start_next   = 1'b0;
        stop_next    = 1'b0;
        bv_next      = 1'b0;
        data_next    = data_reg;
        ack_next     = ack_reg;
        perr_next    = 1'b0;
        arb_set      = '0;

        if (start_cond) begin
            // START (or repeated START) wins over a coincident SCL rise
            perr_next    = in_partial;
            state_next   = ST_BITS;
            bit_cnt_next = 4'd0;
            shift_next   = 8'h00;
            busy_next    = 1'b1;
            start_next   = 1'b1;
        end else if (stop_cond) begin
            perr_next    = in_partial;
            state_next   = ST_IDLE;
            bit_cnt_next = 4'd0;
            busy_next    = 1'b0;
            stop_next    = 1'b1;
        end else if (scl_rise) begin
            unique case (state_reg)
                ST_BITS: begin
                    shift_next   = {shift_reg[6:0], s_sda};
                    bit_cnt_next = bit_cnt_inc;
                    if (bit_cnt_inc == 4'd8) begin
                        state_next = ST_ACK;
                    end
                    // An agent that wanted a 1 but sees a 0 has lost
                    for (int i = 0; i < NUM_AGENTS; i++) begin
                        arb_set[i] = s_intent[i] && !s_sda;
                    end
                end
                ST_ACK: begin
                    data_next    = shift_reg;
                    ack_next     = !s_sda;
                    bv_next      = 1'b1;
                    bit_cnt_next = 4'd0;
                    state_next   = ST_BITS;
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end

        // Clear applies first so that a simultaneous set survives
        arb_next = (arb_reg & ~arb_clr) | arb_set;
    end

    // Frame tracker state register and registered outputs
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 8'h00;
            busy_reg    <= 1'b0;
            start_reg   <= 1'b0;
            stop_reg    <= 1'b0;
            bv_reg      <= 1'b0;
            data_reg    <= 8'h00;
            ack_reg     <= 1'b0;
            arb_reg     <= '0;
            perr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            busy_reg    <= busy_next;
            start_reg   <= start_next;
            stop_reg    <= stop_next;
            bv_reg      <= bv_next;
            data_reg    <= data_next;
            ack_reg     <= ack_next;
            arb_reg     <= arb_next;
            perr_reg    <= perr_next;
        end
    end

    assign bus_busy   = busy_reg;
    assign start_det  = start_reg;
    assign stop_det   = stop_reg;
    assign byte_valid = bv_reg;
    assign byte_data  = data_reg;
    assign byte_ack   = ack_reg;
    assign arb_lost   = arb_reg;
    assign proto_err  = perr_reg;

endmodule

// File: tb/tb_i2c_multi_agent_bus_monitor.sv
// Bench for i2c_multi_agent_bus_monitor: directed bus transactions plus
// randomized traffic, checked every cycle against a transaction-level model.
module tb_i2c_multi_agent_bus_monitor;

    localparam int NA = 3;
    localparam int SS = 3;
    localparam int Q  = 3;

    logic          PCLK = 1'b0;
    logic          PRESETN = 1'b0;
    logic [NA-1:0] scl_o = '0;
    logic [NA-1:0] scl_oe = '0;
    logic [NA-1:0] sda_o = '0;
    logic [NA-1:0] sda_oe = '0;
    logic [NA-1:0] arb_clr = '0;
    logic          SCL;
    logic          SDA;
    logic          bus_busy;
    logic          start_det;
    logic          stop_det;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ack;
    logic [NA-1:0] arb_lost;
    logic          proto_err;

    i2c_multi_agent_bus_monitor #(
        .NUM_AGENTS (NA),
        .SYNC_STAGES(SS)
    ) dut (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .scl_o     (scl_o),
        .scl_oe    (scl_oe),
        .sda_o     (sda_o),
        .sda_oe    (sda_oe),
        .arb_clr   (arb_clr),
        .SCL       (SCL),
        .SDA       (SDA),
        .bus_busy  (bus_busy),
        .start_det (start_det),
        .stop_det  (stop_det),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ack  (byte_ack),
        .arb_lost  (arb_lost),
        .proto_err (proto_err)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Line value a set of open-drain agents produces
    function automatic logic wired_and(input logic [NA-1:0] o, input logic [NA-1:0] oe);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NA; i++) begin
            if (oe[i] === 1'b1 && o[i] === 1'b0) r = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [NA-1:0] wants_high(input logic [NA-1:0] o, input logic [NA-1:0] oe);
        logic [NA-1:0] r;
        for (int i = 0; i < NA; i++) r[i] = (oe[i] === 1'b1) && (o[i] === 1'b1);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: the monitor sees the bus SS cycles late; it then
    // collects bits of a frame in a queue and closes a byte at the 9th bit.
    // ------------------------------------------------------------------
    logic          hs [0:SS+1];
    logic          hd [0:SS+1];
    logic [NA-1:0] hi [0:SS+1];
    bit            bq [$];
    logic          m_busy = 0, m_start = 0, m_stop = 0, m_bv = 0, m_ack = 0, m_perr = 0;
    logic [7:0]    m_data = 8'h00;
    logic [NA-1:0] m_arb = '0;

    always @(posedge PCLK or negedge PRESETN) begin
        logic          sc, sp, dc, dp;
        logic [NA-1:0] set;
        logic [7:0]    d;
        if (!PRESETN) begin
            for (int k = 0; k <= SS + 1; k++) begin
                hs[k] = 1'b1; hd[k] = 1'b1; hi[k] = '0;
            end
            bq.delete();
            m_busy = 0; m_start = 0; m_stop = 0; m_bv = 0; m_ack = 0; m_perr = 0;
            m_data = 8'h00; m_arb = '0;
        end else begin
            for (int k = SS + 1; k > 0; k--) begin
                hs[k] = hs[k-1]; hd[k] = hd[k-1]; hi[k] = hi[k-1];
            end
            hs[0] = wired_and(scl_o, scl_oe);
            hd[0] = wired_and(sda_o, sda_oe);
            hi[0] = wants_high(sda_o, sda_oe);
            sc = hs[SS]; sp = hs[SS+1]; dc = hd[SS]; dp = hd[SS+1];
            m_start = 0; m_stop = 0; m_bv = 0; m_perr = 0; set = '0;
            if (sp && sc && (dp != dc)) begin
                m_perr  = m_busy && (bq.size() > 0);
                m_start = !dc;
                m_stop  = dc;
                m_busy  = !dc;
                bq.delete();
            end else if (!sp && sc && m_busy) begin
                if (bq.size() < 8) begin
                    for (int i = 0; i < NA; i++) set[i] = hi[SS][i] && !dc;
                end
                bq.push_back(dc);
                if (bq.size() == 9) begin
                    d = 8'h00;
                    for (int k = 0; k < 8; k++) d = d * 8'd2 + 8'(bq[k]);
                    m_data = d;
                    m_ack  = !dc;
                    m_bv   = 1;
                    bq.delete();
                    $display("BYTE data=%02h ack=%0b t=%0t", d, !dc, $time);
                end
            end
            m_arb = (m_arb & ~arb_clr) | set;
        end
    end

    // Compare every cycle and count DUT pulses for the directed checks
    int n_start = 0, n_stop = 0, n_bv = 0, n_perr = 0;

    always @(negedge PCLK) begin
        chk("SCL", 32'(SCL), 32'(wired_and(scl_o, scl_oe)));
        chk("SDA", 32'(SDA), 32'(wired_and(sda_o, sda_oe)));
        chk("bus_busy", 32'(bus_busy), 32'(m_busy));
        chk("start_det", 32'(start_det), 32'(m_start));
        chk("stop_det", 32'(stop_det), 32'(m_stop));
        chk("byte_valid", 32'(byte_valid), 32'(m_bv));
        chk("byte_data", 32'(byte_data), 32'(m_data));
        chk("byte_ack", 32'(byte_ack), 32'(m_ack));
        chk("arb_lost", 32'(arb_lost), 32'(m_arb));
        chk("proto_err", 32'(proto_err), 32'(m_perr));
        n_start += int'(start_det);
        n_stop  += int'(stop_det);
        n_bv    += int'(byte_valid);
        n_perr  += int'(proto_err);
    end

    // ------------------------------------------------------------------
    // Bus driving helpers; agent 0 is the clock master
    // ------------------------------------------------------------------
    task automatic w(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic bus_start();
        sda_oe = '0; w(Q);
        scl_oe = '0; w(Q);
        sda_oe[0] = 1'b1; sda_o[0] = 1'b0; w(Q);
        scl_oe[0] = 1'b1; scl_o[0] = 1'b0; w(Q);
    endtask

    task automatic bus_bit(input logic [NA-1:0] en, input logic [NA-1:0] val);
        sda_oe = en; sda_o = val; w(Q);
        scl_oe[0] = 1'b0; w(2 * Q);
        scl_oe[0] = 1'b1; scl_o[0] = 1'b0; w(Q);
    endtask

    task automatic bus_stop();
        sda_oe = '0; sda_oe[0] = 1'b1; sda_o[0] = 1'b0; w(Q);
        scl_oe[0] = 1'b0; w(Q);
        sda_oe = '0; w(2 * Q);
    endtask

    task automatic send_byte(input int a, input logic [7:0] b, input logic [NA-1:0] ackers);
        logic [NA-1:0] en, val;
        for (int k = 7; k >= 0; k--) begin
            en = '0; val = '0; en[a] = 1'b1; val[a] = b[k];
            bus_bit(en, val);
        end
        bus_bit(ackers, '0);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, p0, b0, e0;
        logic [NA-1:0] en, val;
        logic [7:0] c0, c2;

        // Reset state
        w(4);
        chk("rst_busy", 32'(bus_busy), 32'd0);
        chk("rst_data", 32'(byte_data), 32'h00);
        chk("rst_arb", 32'(arb_lost), 32'd0);
        PRESETN = 1'b1;
        w(10);

        // Agent 0 writes A5, agent 1 ACKs
        s0 = n_start; p0 = n_stop; b0 = n_bv;
        bus_start();
        send_byte(0, 8'hA5, 3'b010);
        bus_stop();
        w(12);
        chk("a5_start_cnt", 32'(n_start - s0), 32'd1);
        chk("a5_stop_cnt", 32'(n_stop - p0), 32'd1);
        chk("a5_bv_cnt", 32'(n_bv - b0), 32'd1);
        chk("a5_data", 32'(byte_data), 32'hA5);
        chk("a5_ack", 32'(byte_ack), 32'd1);
        chk("a5_busy", 32'(bus_busy), 32'd0);

        // Released bus with an undefined enable stays high, nothing fires
        s0 = n_start; p0 = n_stop; b0 = n_bv; e0 = n_perr;
        scl_oe = 3'b0x0; sda_oe = 3'bx00; scl_o = '0; sda_o = '0;
        w(12);
        chk("x_scl", 32'(SCL), 32'd1);
        chk("x_sda", 32'(SDA), 32'd1);
        chk("x_pulses", 32'((n_start - s0) + (n_stop - p0) + (n_bv - b0) + (n_perr - e0)), 32'd0);
        scl_oe = '0; sda_oe = '0;
        w(6);

        // Agents 0 and 2 contend with C0 and 80
        c0 = 8'hC0; c2 = 8'h80;
        bus_start();
        for (int k = 7; k >= 0; k--) begin
            en = 3'b101; val = '0; val[0] = c0[k]; val[2] = c2[k];
            bus_bit(en, val);
            if (k == 7) chk("arb_bit1", 32'(arb_lost), 32'd0);
            if (k == 6) chk("arb_bit2", 32'(arb_lost), 32'b001);
        end
        bus_bit(3'b010, '0);
        w(6);
        chk("arb_data", 32'(byte_data), 32'h80);
        chk("arb_final", 32'(arb_lost), 32'b001);
        arb_clr = 3'b001; w(1); arb_clr = '0; w(1);
        chk("arb_clr", 32'(arb_lost), 32'd0);
        bus_stop();
        w(10);

        // Four data bits then STOP
        e0 = n_perr; b0 = n_bv;
        bus_start();
        for (int k = 0; k < 4; k++) bus_bit(3'b001, {2'b00, 1'(k % 2)});
        bus_stop();
        w(12);
        chk("part_perr", 32'(n_perr - e0), 32'd1);
        chk("part_bv", 32'(n_bv - b0), 32'd0);
        chk("part_busy", 32'(bus_busy), 32'd0);

        // 3C ACK, repeated START, FF NACK
        s0 = n_start; b0 = n_bv;
        bus_start();
        send_byte(0, 8'h3C, 3'b010);
        w(2);
        chk("rs_ack1", 32'(byte_ack), 32'd1);
        chk("rs_data1", 32'(byte_data), 32'h3C);
        bus_start();
        chk("rs_busy", 32'(bus_busy), 32'd1);
        send_byte(0, 8'hFF, 3'b000);
        w(2);
        chk("rs_ack2", 32'(byte_ack), 32'd0);
        chk("rs_start_cnt", 32'(n_start - s0), 32'd2);
        chk("rs_bv_cnt", 32'(n_bv - b0), 32'd2);
        chk("rs_busy2", 32'(bus_busy), 32'd1);
        bus_stop();
        w(10);

        // Reset in the middle of a byte, then a clean byte 01
        bus_start();
        for (int k = 0; k < 5; k++) bus_bit(3'b001, 3'b001);
        e0 = n_perr; b0 = n_bv;
        PRESETN = 1'b0; w(3);
        sda_oe = '0; scl_oe = '0;
        PRESETN = 1'b1; w(12);
        chk("rst_mid_bv", 32'(n_bv - b0), 32'd0);
        chk("rst_mid_perr", 32'(n_perr - e0), 32'd0);
        chk("rst_mid_busy", 32'(bus_busy), 32'd0);
        e0 = n_perr; b0 = n_bv;
        bus_start();
        send_byte(0, 8'h01, 3'b010);
        w(6);
        chk("new_data", 32'(byte_data), 32'h01);
        chk("new_perr", 32'(n_perr - e0), 32'd0);
        chk("new_bv", 32'(n_bv - b0), 32'd1);
        bus_stop();
        w(10);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    for (int k = 0; k < 9; k++) bus_bit(NA'($urandom), NA'($urandom));
                end
                2: bus_start();
                3: bus_stop();
                4: begin
                    arb_clr = NA'($urandom); w(1); arb_clr = '0; w(1);
                end
                default: begin
                    repeat (20) begin
                        scl_o = NA'($urandom); scl_oe = NA'($urandom);
                        sda_o = NA'($urandom); sda_oe = NA'($urandom);
                        arb_clr = NA'($urandom_range(0, 3) == 0 ? $urandom : 0);
                        if ($urandom_range(0, 7) == 0) sda_oe[$urandom_range(0, NA - 1)] = 1'bx;
                        w($urandom_range(1, 4));
                    end
                    scl_o = '0; scl_oe = '0; sda_oe = '0; sda_o = '0; arb_clr = '0;
                    w(Q);
                end
            endcase
        end
        bus_stop();
        w(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
